// File: rtl/bofs_block_iterator_if.sv
// Handshake bundle between the block-offset generator, its configuration source and the offset expander.
// master = configuration source / offset consumer, slave = bofs_block_iterator.
interface bofs_block_iterator_if #(
  parameter int WBW   = 16,
  parameter int DIM   = 2,
  parameter int VSIZE = 8
);
  localparam int CCV_BW = $clog2($clog2(VSIZE) + 1);

  logic                           cfg_rdy;
  logic                           cfg_ack;
  logic [DIM-1:0][WBW-1:0]        bboundary;
  logic [DIM-1:0][CCV_BW-1:0]     bstep_order;
  logic                           bofs_rdy;
  logic                           bofs_ack;
  logic [DIM-1:0][WBW-1:0]        bofs;
  logic                           bofs_last;
  logic                           busy;

  modport master (
    output cfg_rdy, bboundary, bstep_order, bofs_ack,
    input  cfg_ack, bofs_rdy, bofs, bofs_last, busy
  );

  modport slave (
    input  cfg_rdy, bboundary, bstep_order, bofs_ack,
    output cfg_ack, bofs_rdy, bofs, bofs_last, busy
  );
endinterface

// File: rtl/bofs_block_iterator.sv
// Walks the multi-dimensional block grid in odometer order (innermost dimension DIM-1 first)
// and streams one block offset per downstream handshake, flagging the final offset of each sweep.
module bofs_block_iterator #(
  parameter int WBW   = 16,
  parameter int DIM   = 2,
  parameter int VSIZE = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  bofs_block_iterator_if.slave   bus
);
  localparam int CCV_BW = $clog2($clog2(VSIZE) + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [DIM-1:0][WBW-1:0]     r_bound;
  logic [DIM-1:0][CCV_BW-1:0]  r_order;
  logic [DIM-1:0][WBW-1:0]     r_ofs;
  logic [DIM-1:0][WBW-1:0]     w_ofs_next;
  logic [DIM-1:0]              w_wrap;
  logic [DIM-1:0]              w_carry_in;
  logic [DIM-1:0]              w_bound_zero;
  logic                        w_last;
  logic                        w_empty;
  logic                        w_cfg_fire;
  logic                        w_bofs_fire;
  logic                        w_cfg_ack;
  logic                        w_bofs_rdy;
  logic                        w_bofs_last;
  logic                        w_busy;

  // Per-dimension step/wrap logic; the sum keeps one extra bit so a bound near 2^WBW
  // is detected as a carry instead of silently wrapping back to a small offset.
  for (genvar gi = 0; gi < DIM; gi++) begin : g_dim
    logic [WBW:0] w_sum;

    assign w_sum        = {1'b0, r_ofs[gi]} + ((WBW+1)'(1) << r_order[gi]);
    assign w_wrap[gi]   = w_sum[WBW] || (w_sum >= {1'b0, r_bound[gi]});
    assign w_bound_zero[gi] = (bus.bboundary[gi] == '0);

    if (gi == DIM - 1) begin : g_inner
      assign w_carry_in[gi] = 1'b1;
    end else begin : g_outer
      assign w_carry_in[gi] = &w_wrap[DIM-1:gi+1];
    end

    assign w_ofs_next[gi] = !w_carry_in[gi] ? r_ofs[gi] :
                            (w_wrap[gi] ? '0 : w_sum[WBW-1:0]);
  end

  // Every dimension carrying at once is exactly the carry out of dimension 0.
  assign w_last  = &w_wrap;
  assign w_empty = |w_bound_zero;

  always_comb begin
    w_state_next = r_state;
    w_cfg_fire   = 1'b0;
    w_bofs_fire  = 1'b0;
    w_cfg_ack    = 1'b0;
    w_bofs_rdy   = 1'b0;
    w_bofs_last  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cfg_ack = 1'b1;
        if (bus.cfg_rdy) begin
          w_cfg_fire = 1'b1;
          if (!w_empty) begin
            w_state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_bofs_rdy  = 1'b1;
        w_busy      = 1'b1;
        w_bofs_last = w_last;
        if (bus.bofs_ack) begin
          w_bofs_fire = 1'b1;
          if (w_last) begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_bound <= '0;
      r_order <= '0;
      r_ofs   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_cfg_fire) begin
        r_bound <= bus.bboundary;
        r_order <= bus.bstep_order;
        r_ofs   <= '0;
      end else if (w_bofs_fire) begin
        // The final advance wraps every dimension, leaving the offset at zero for the next sweep.
        r_ofs <= w_ofs_next;
      end
    end
  end

  assign bus.cfg_ack   = w_cfg_ack;
  assign bus.bofs_rdy  = w_bofs_rdy;
  assign bus.bofs_last = w_bofs_last;
  assign bus.busy      = w_busy;
  assign bus.bofs      = r_ofs;
endmodule

// File: tb/tb_bofs_block_iterator.sv
// Self-checking bench for bofs_block_iterator: directed and randomized sweeps compared
// against a nested-loop enumeration of the block grid.
module tb_bofs_block_iterator;
  localparam int WBW    = 16;
  localparam int DIM    = 2;
  localparam int VSIZE  = 8;
  localparam int CCV_BW = $clog2($clog2(VSIZE) + 1);

  typedef logic [DIM-1:0][WBW-1:0]    vec_t;
  typedef logic [DIM-1:0][CCV_BW-1:0] ord_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bofs_block_iterator_if #(.WBW(WBW), .DIM(DIM), .VSIZE(VSIZE)) bus ();

  bofs_block_iterator #(.WBW(WBW), .DIM(DIM), .VSIZE(VSIZE)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];

  function automatic vec_t mk(input int d0, input int d1);
    vec_t v;
    v[0] = WBW'(d0);
    v[1] = WBW'(d1);
    return v;
  endfunction

  function automatic ord_t mko(input int d0, input int d1);
    ord_t v;
    v[0] = CCV_BW'(d0);
    v[1] = CCV_BW'(d1);
    return v;
  endfunction

  // Reference: the grid is every step multiple below each bound, outer dimension slowest.
  function automatic void build_model(input vec_t b, input ord_t o);
    int s0;
    int s1;
    exp_q.delete();
    s0 = 1 << o[0];
    s1 = 1 << o[1];
    for (int a = 0; a < int'(b[0]); a += s0) begin
      for (int c = 0; c < int'(b[1]); c += s1) begin
        exp_q.push_back(mk(a, c));
      end
    end
  endfunction

  // mode 0: ack always high, 1: ack toggles 1/0, 2: random ack
  task automatic test_sweep(input vec_t b, input ord_t o, input int mode, input string name);
    int idx;
    int cyc;
    int budget;
    int n;
    build_model(b, o);
    n = exp_q.size();
    bus.cfg_rdy     = 1'b1;
    bus.bboundary   = b;
    bus.bstep_order = o;
    bus.bofs_ack    = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cfg_ack !== 1'b1)
      begin errors++; $display("FAIL %s cfg_ack_before: got %b want 1", name, bus.cfg_ack); end
    checks++;
    if (bus.bofs_rdy !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL %s idle_before: got rdy=%b busy=%b want 0/0", name, bus.bofs_rdy, bus.busy); end
    @(posedge clk);
    #1;
    // Garbage on the config inputs while running must be ignored.
    bus.cfg_rdy     = (n != 0);
    bus.bboundary   = vec_t'($urandom);
    bus.bstep_order = ord_t'($urandom);
    budget = n * 4 + 8;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < budget) begin
      case (mode)
        0:       bus.bofs_ack = 1'b1;
        1:       bus.bofs_ack = (cyc % 2 == 0);
        default: bus.bofs_ack = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      checks++;
      if (bus.bofs_rdy !== 1'b1 || bus.busy !== 1'b1 || bus.cfg_ack !== 1'b0)
        begin errors++; $display("FAIL %s run_hs[%0d]: got rdy=%b busy=%b cfg_ack=%b want 1/1/0", name, idx, bus.bofs_rdy, bus.busy, bus.cfg_ack); end
      checks++;
      if (bus.bofs !== exp_q[idx])
        begin errors++; $display("FAIL %s ofs[%0d]: got (%0d,%0d) want (%0d,%0d)", name, idx, bus.bofs[0], bus.bofs[1], exp_q[idx][0], exp_q[idx][1]); end
      checks++;
      if (bus.bofs_last !== (idx == n - 1))
        begin errors++; $display("FAIL %s last[%0d]: got %b want %b", name, idx, bus.bofs_last, (idx == n - 1)); end
      if (bus.bofs_ack) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (idx < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d transfers want %0d", name, idx, n);
    end
    bus.cfg_rdy  = 1'b0;
    bus.bofs_ack = 1'b0;
    if (n == 0) begin
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (bus.bofs_rdy !== 1'b0 || bus.cfg_ack !== 1'b1)
          begin errors++; $display("FAIL %s empty_idle: got rdy=%b cfg_ack=%b want 0/1", name, bus.bofs_rdy, bus.cfg_ack); end
        @(posedge clk);
        #1;
      end
    end
    $display("sweep %s: bound=(%0d,%0d) order=(%0d,%0d) expected=%0d transfers=%0d cycles=%0d",
             name, b[0], b[1], o[0], o[1], n, idx, cyc);
  endtask

  task automatic test_reset();
    bus.cfg_rdy     = 1'b0;
    bus.bofs_ack    = 1'b0;
    bus.bboundary   = '0;
    bus.bstep_order = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.cfg_ack !== 1'b1 || bus.bofs_rdy !== 1'b0 || bus.bofs_last !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL reset_ctrl: got ack=%b rdy=%b last=%b busy=%b want 1/0/0/0", bus.cfg_ack, bus.bofs_rdy, bus.bofs_last, bus.busy); end
    checks++;
    if (bus.bofs !== '0)
      begin errors++; $display("FAIL reset_ofs: got %h want 0", bus.bofs); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("reset: released");
  endtask

  task automatic test_basic();
    test_sweep(mk(2, 8), mko(0, 2), 0, "basic");
    test_sweep(mk(3, 5), mko(1, 1), 0, "odd_bounds");
  endtask

  task automatic test_stall();
    test_sweep(mk(2, 8), mko(0, 2), 1, "stall");
  endtask

  task automatic test_empty_single();
    test_sweep(mk(0, 8), mko(0, 2), 0, "empty");
    test_sweep(mk(1, 1), mko(0, 0), 0, "single");
    test_sweep(mk(1, 3), mko(2, 3), 1, "single_small");
  endtask

  task automatic test_wbw_edge();
    test_sweep(mk(1, (1 << WBW) - 1), mko(0, 3), 0, "wbw_edge");
  endtask

  task automatic test_reset_mid();
    bus.cfg_rdy     = 1'b1;
    bus.bboundary   = mk(2, 8);
    bus.bstep_order = mko(0, 2);
    @(posedge clk);
    #1;
    bus.cfg_rdy  = 1'b0;
    bus.bofs_ack = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (bus.bofs !== mk(1, 0) || bus.bofs_rdy !== 1'b1)
      begin errors++; $display("FAIL midreset_pre: got (%0d,%0d) rdy=%b want (1,0) rdy=1", bus.bofs[0], bus.bofs[1], bus.bofs_rdy); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cfg_ack !== 1'b1 || bus.bofs_rdy !== 1'b0 || bus.bofs_last !== 1'b0 || bus.busy !== 1'b0 || bus.bofs !== '0)
      begin errors++; $display("FAIL midreset_async: got ack=%b rdy=%b last=%b busy=%b ofs=%h want 1/0/0/0/0", bus.cfg_ack, bus.bofs_rdy, bus.bofs_last, bus.busy, bus.bofs); end
    @(negedge clk);
    checks++;
    if (bus.bofs_rdy !== 1'b0)
      begin errors++; $display("FAIL midreset_held: got rdy=%b want 0", bus.bofs_rdy); end
    rst_n = 1'b1;
    bus.bofs_ack = 1'b0;
    @(posedge clk);
    #1;
    $display("midreset: aborted after 2 transfers");
    test_sweep(mk(2, 8), mko(0, 2), 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      test_sweep(mk($urandom_range(0, 12), $urandom_range(0, 12)),
                 mko($urandom_range(0, 3), $urandom_range(0, 3)), 2, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_empty_single();
    test_wbw_edge();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    checks++;
    if (bus.cfg_ack !== 1'b1 || bus.bofs_rdy !== 1'b0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL final_idle: got ack=%b rdy=%b busy=%b want 1/0/0", bus.cfg_ack, bus.bofs_rdy, bus.busy); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
